position_stepper_ctrl: RTL and testbench
========================================

POSITION_STEPPER_CTRL -- requirements
Module: position_stepper_ctrl

Interface
REQ-001 Parameter POS_W, default 3, SHALL set position width; positions 0..2^POS_W-1, wrap modulo 2^POS_W.
REQ-002 Parameter STEP_DIV, default 4, SHALL set the number of WAIT cycles after each step pulse; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 64, SHALL set the no-motion fault limit in cycles; used only under the macro in REQ-026.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cw  input  1  increment desiredPosition by 1 in each cycle it is high.
REQ-007 ccw  input  1  decrement desiredPosition by 1 in each cycle it is high.
REQ-008 sync  input  1  load physicalPosition into desiredPosition and clear fault.
REQ-009 physicalPosition  input  POS_W  measured position, synchronous to clk.
REQ-010 desiredPosition  output  POS_W  commanded target position, registered.
REQ-011 stepPulse  output  1  one-cycle motor step strobe, registered.
REQ-012 stepDir  output  1  1 = cw, 0 = ccw; valid while stepPulse is high, holds last value otherwise.
REQ-013 busy  output  1  high in STEP and WAIT.
REQ-014 atTarget  output  1  combinational: desiredPosition == physicalPosition.
REQ-015 fault  output  1  sticky no-motion fault.

Function
REQ-016 Target update priority per cycle SHALL be: sync, then cw and ccw both high (no change), then cw (+1), then ccw (-1), else hold; 2^POS_W-1 +1 -> 0 and 0 -1 -> 2^POS_W-1.
REQ-017 The FSM SHALL have states IDLE, STEP, WAIT, FAULT, with reset state IDLE.
REQ-018 IDLE -> STEP in the cycle after desiredPosition != physicalPosition is sampled; otherwise IDLE holds.
REQ-019 In STEP the block SHALL assert stepPulse for exactly one cycle, latch stepDir, then go to WAIT.
REQ-020 Direction SHALL be the shortest path: d = (desired - physical) mod 2^POS_W; d < 2^(POS_W-1) -> cw; d > 2^(POS_W-1) -> ccw; d == 2^(POS_W-1) -> cw.
REQ-021 WAIT SHALL last exactly STEP_DIV cycles, then return to IDLE, so a move of k positions produces k step pulses spaced STEP_DIV+2 cycles apart.
REQ-022 A desiredPosition change during STEP or WAIT SHALL NOT abort the current step; the new target is used at the next IDLE evaluation.
REQ-023 sync asserted in any state SHALL force IDLE in the next cycle and suppress any stepPulse in that cycle.

Reset
REQ-024 While rst is high: desiredPosition = 0, stepPulse = 0, stepDir = 0, busy = 0, fault = 0, state = IDLE, all counters = 0, independent of clk.
REQ-025 After rst deasserts, the block SHALL start stepping toward 0 unless sync is asserted first; sync in the first post-reset cycle SHALL result in no step pulses.

Configuration
REQ-026 With POSITION_STEPPER_TIMEOUT_EN defined: after each stepPulse, if physicalPosition does not change within TIMEOUT cycles, the FSM SHALL enter FAULT, fault = 1, and stepping stops; FAULT exits only on sync (-> IDLE) or rst.
REQ-027 Without POSITION_STEPPER_TIMEOUT_EN: the timeout counter and FAULT state SHALL NOT exist, and fault SHALL be tied to 0.
REQ-028 Under the macro, the timeout counter SHALL keep running across WAIT and IDLE until motion is seen or the limit is reached.

Structure
REQ-029 A shared package position_pkg SHALL hold the state enumeration (IDLE, STEP, WAIT, FAULT) and the default parameter constants.
REQ-030 The cycle timing SHALL be a sub-module step_timer, a loadable down-counter with a done flag, used for WAIT and the timeout.

Verification
REQ-031 POS_W=3, rst, then sync with physicalPosition=0, then cw for 3 cycles with the bench echoing each step into physicalPosition: desiredPosition=3, exactly 3 pulses with stepDir=1, spaced 6 cycles, then atTarget=1.
REQ-032 Wrap: desiredPosition=0, ccw for 1 cycle: desiredPosition=7, 1 pulse with stepDir=0.
REQ-033 Tie and simultaneous inputs: cw=ccw=1 for 5 cycles: desiredPosition unchanged; with physicalPosition=0 and desired=4, stepDir=1.
REQ-034 Mid-move: sync asserted during WAIT of a 4-step move: no further pulses, desiredPosition = physicalPosition, busy=0 next cycle.
REQ-035 Macro defined, TIMEOUT=64, physicalPosition held fixed after a pulse: fault=1 at cycle 64 after the pulse, no more pulses; sync clears fault.
REQ-036 Async reset asserted mid-WAIT between clock edges: all outputs go to their reset values immediately.

Source files
------------

// File: rtl/position_pkg.sv
// -----------------------------------------------------------------------------
// position_pkg
// Shared definitions for the position stepper controller.
//   state_t       : controller FSM states (IDLE, STEP, WAIT, FAULT)
//   DEF_POS_W     : default position width
//   DEF_STEP_DIV  : default WAIT length in cycles after each step pulse
//   DEF_TIMEOUT   : default no-motion fault limit in cycles
//   WAIT_CNT_W    : width of the WAIT down-counter (holds STEP_DIV-1, max 254)
// -----------------------------------------------------------------------------
package position_pkg;

   localparam int DEF_POS_W    = 3;
   localparam int DEF_STEP_DIV = 4;
   localparam int DEF_TIMEOUT  = 64;
   localparam int WAIT_CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STEP  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Loadable down-counter with a done flag. A load has priority over counting;
// while enabled the count decrements and sticks at zero.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   i_load      : load i_load_val into the counter this cycle
//   i_load_val  : value to load
//   i_en        : decrement enable
//   o_done      : high while the count is zero
// -----------------------------------------------------------------------------
module step_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/position_stepper_ctrl.sv
// -----------------------------------------------------------------------------
// position_stepper_ctrl
// Tracks a commanded target position (cw/ccw/sync) and issues one step pulse
// at a time toward it along the shortest modular path, followed by a WAIT of
// STEP_DIV cycles. Pulses of a multi-position move are STEP_DIV+2 cycles apart
// (STEP + WAIT + one IDLE evaluation cycle).
//
// Optional feature: define POSITION_STEPPER_TIMEOUT_EN to enable the no-motion
// fault. The timer starts at a step pulse, keeps running through WAIT and IDLE
// and is cleared as soon as physicalPosition changes; on expiry the FSM parks
// in FAULT (fault=1) until sync or rst. Without the macro fault is tied to 0.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cw, ccw           : +1 / -1 target each cycle high (both high: hold)
//   sync              : target <= physicalPosition, clear fault, force IDLE
//   physicalPosition  : measured position (synchronous to clk)
//   desiredPosition   : registered target position
//   stepPulse         : registered one-cycle step strobe
//   stepDir           : 1 = cw, 0 = ccw; holds its last value between pulses
//   busy              : high in STEP and WAIT
//   atTarget          : desiredPosition == physicalPosition (combinational)
//   fault             : sticky no-motion fault
//   o_dbg_state       : current FSM state, for observation only
//
// Handshake: none; cw/ccw/sync are level commands sampled every rising edge.
// -----------------------------------------------------------------------------
module position_stepper_ctrl
   import position_pkg::*;
#(
   parameter int POS_W    = DEF_POS_W,
   parameter int STEP_DIV = DEF_STEP_DIV,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cw,
   input  logic             ccw,
   input  logic             sync,
   input  logic [POS_W-1:0] physicalPosition,
   output logic [POS_W-1:0] desiredPosition,
   output logic             stepPulse,
   output logic             stepDir,
   output logic             busy,
   output logic             atTarget,
   output logic             fault,
   output state_t           o_dbg_state
);

   // Half of the position circle; a tie at exactly half goes cw.
   localparam logic [POS_W-1:0] HALF = {1'b1, {(POS_W-1){1'b0}}};

   state_t           r_state;
   state_t           w_next_state;
   logic [POS_W-1:0] r_desired;
   logic [POS_W-1:0] w_desired_next;
   logic [POS_W-1:0] w_diff;
   logic             r_pulse;
   logic             r_dir;
   logic             w_dir;
   logic             w_mismatch;
   logic             w_wait_load;
   logic             w_wait_done;
   logic             w_timeout;

   assign w_mismatch = (r_desired != physicalPosition);
   assign w_diff     = r_desired - physicalPosition;
   assign w_dir      = (w_diff <= HALF);

   // Target update: sync wins, then cw+ccw cancel, then cw, then ccw.
   always_comb begin
      w_desired_next = r_desired;
      if (sync) begin
         w_desired_next = physicalPosition;
      end else if (cw && ccw) begin
         w_desired_next = r_desired;
      end else if (cw) begin
         w_desired_next = r_desired + POS_W'(1);
      end else if (ccw) begin
         w_desired_next = r_desired - POS_W'(1);
      end
   end

   // Next-state logic. The WAIT timer is loaded during STEP so that WAIT
   // sees STEP_DIV-1 .. 0 and lasts exactly STEP_DIV cycles.
   always_comb begin
      w_next_state = r_state;
      w_wait_load  = 1'b0;
      case (r_state)
         ST_IDLE:  if (w_mismatch) w_next_state = ST_STEP;
         ST_STEP:  begin
            w_next_state = ST_WAIT;
            w_wait_load  = 1'b1;
         end
         ST_WAIT:  if (w_wait_done) w_next_state = ST_IDLE;
         ST_FAULT: w_next_state = ST_FAULT;
         default:  w_next_state = ST_IDLE;
      endcase
      if (w_timeout && (r_state != ST_FAULT)) begin
         w_next_state = ST_FAULT;
      end
      if (sync) begin
         w_next_state = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_desired <= '0;
         r_pulse   <= 1'b0;
         r_dir     <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_desired <= w_desired_next;
         // Pulse is registered: it is high exactly during the STEP cycle.
         r_pulse   <= (w_next_state == ST_STEP);
         if (w_next_state == ST_STEP) begin
            r_dir <= w_dir;
         end
      end
   end

   step_timer #(
      .W(WAIT_CNT_W)
   ) u_wait_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_wait_load),
      .i_load_val (WAIT_CNT_W'(STEP_DIV - 1)),
      .i_en       (r_state == ST_WAIT),
      .o_done     (w_wait_done)
   );

`ifdef POSITION_STEPPER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [POS_W-1:0] r_phys_prev;
   logic             r_armed;
   logic             w_motion;
   logic             w_to_load;
   logic             w_to_done;

   assign w_motion  = (physicalPosition != r_phys_prev);
   // Only a pulse that finds the timer idle restarts it; later pulses of an
   // unanswered move keep the original deadline running.
   assign w_to_load = (r_state == ST_STEP) && !r_armed;
   // Loaded with TIMEOUT-2: the expiry cycle plus the FAULT register make
   // fault visible TIMEOUT cycles after the pulse cycle.
   assign w_timeout = r_armed && w_to_done && !w_motion;
   assign fault     = (r_state == ST_FAULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phys_prev <= '0;
         r_armed     <= 1'b0;
      end else begin
         r_phys_prev <= physicalPosition;
         if (sync || (r_state == ST_FAULT) || w_motion) begin
            r_armed <= 1'b0;
         end else if (r_state == ST_STEP) begin
            r_armed <= 1'b1;
         end
      end
   end

   step_timer #(
      .W(TO_W)
   ) u_timeout_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_to_load),
      .i_load_val (TO_W'(TIMEOUT - 2)),
      .i_en       (r_armed),
      .o_done     (w_to_done)
   );
`else
   assign w_timeout = 1'b0;
   assign fault     = 1'b0;
`endif

   assign desiredPosition = r_desired;
   assign stepPulse       = r_pulse;
   assign stepDir         = r_dir;
   assign busy            = (r_state == ST_STEP) || (r_state == ST_WAIT);
   assign atTarget        = !w_mismatch;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_position_stepper_ctrl.sv
// -----------------------------------------------------------------------------
// tb_position_stepper_ctrl
// Directed bench for position_stepper_ctrl with POS_W=3, STEP_DIV=4,
// TIMEOUT=64. Inputs are driven and outputs sampled 1 ns after each rising
// edge. With echo enabled the bench models a motor that follows every pulse.
// -----------------------------------------------------------------------------
module tb_position_stepper_ctrl;
   import position_pkg::*;

   localparam int POS_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             cw;
   logic             ccw;
   logic             sync;
   logic [POS_W-1:0] phys;
   logic [POS_W-1:0] desired;
   logic             step_pulse;
   logic             step_dir;
   logic             busy;
   logic             at_target;
   logic             fault;
   state_t           dbg_state;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   echo_en  = 1'b0;
   int   pulse_cyc_q[$];
   logic pulse_dir_q[$];

   always #5 clk = ~clk;

   position_stepper_ctrl #(
      .POS_W    (POS_W),
      .STEP_DIV (4),
      .TIMEOUT  (64)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cw               (cw),
      .ccw              (ccw),
      .sync             (sync),
      .physicalPosition (phys),
      .desiredPosition  (desired),
      .stepPulse        (step_pulse),
      .stepDir          (step_dir),
      .busy             (busy),
      .atTarget         (at_target),
      .fault            (fault),
      .o_dbg_state      (dbg_state)
   );

   // One clock: sample after the edge, log pulses, optionally move the motor.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (step_pulse === 1'b1) begin
         pulse_cyc_q.push_back(cyc);
         pulse_dir_q.push_back(step_dir);
         if (echo_en) phys = step_dir ? phys + 3'd1 : phys - 3'd1;
      end
   endtask

   task automatic clear_log();
      pulse_cyc_q.delete();
      pulse_dir_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; cw = 1'b0; ccw = 1'b0; sync = 1'b0; phys = 3'd5;
      repeat (2) tick();
      n_checks++; if (desired !== 3'd0) begin n_fail++; $display("FAIL reset_desired: got %0d expected 0", desired); end
      n_checks++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", step_pulse); end
      n_checks++; if (step_dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b expected 0", step_dir); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      // sync in the very first post-reset cycle: adopt position, never step
      rst = 1'b0; sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (desired !== 3'd5) begin n_fail++; $display("FAIL first_sync_desired: got %0d expected 5", desired); end
      clear_log();
      repeat (20) tick();
      n_checks++; if (pulse_cyc_q.size() !== 0) begin n_fail++; $display("FAIL first_sync_pulses: got %0d expected 0", pulse_cyc_q.size()); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_sync_busy: got %b expected 0", busy); end
   endtask

   task automatic test_post_reset_seek();
      int bad_dir;
      rst = 1'b1; phys = 3'd2;
      tick();
      rst = 1'b0; echo_en = 1'b1;
      clear_log();
      repeat (30) tick();
      bad_dir = 0;
      foreach (pulse_dir_q[i]) if (pulse_dir_q[i] !== 1'b0) bad_dir++;
      n_checks++; if (pulse_cyc_q.size() !== 2) begin n_fail++; $display("FAIL seek_pulses: got %0d expected 2", pulse_cyc_q.size()); end
      n_checks++; if (bad_dir !== 0) begin n_fail++; $display("FAIL seek_dir: got %0d cw pulses expected 0", bad_dir); end
      n_checks++; if (phys !== 3'd0) begin n_fail++; $display("FAIL seek_final_pos: got %0d expected 0", phys); end
   endtask

   task automatic test_cw_move();
      int bad_dir;
      int gap0;
      int gap1;
      phys = 3'd0; sync = 1'b1;
      tick();
      sync = 1'b0;
      clear_log();
      cw = 1'b1;
      repeat (3) tick();
      cw = 1'b0;
      n_checks++; if (desired !== 3'd3) begin n_fail++; $display("FAIL cw_desired: got %0d expected 3", desired); end
      repeat (30) tick();
      bad_dir = 0;
      foreach (pulse_dir_q[i]) if (pulse_dir_q[i] !== 1'b1) bad_dir++;
      gap0 = (pulse_cyc_q.size() >= 3) ? pulse_cyc_q[1] - pulse_cyc_q[0] : -1;
      gap1 = (pulse_cyc_q.size() >= 3) ? pulse_cyc_q[2] - pulse_cyc_q[1] : -1;
      n_checks++; if (pulse_cyc_q.size() !== 3) begin n_fail++; $display("FAIL cw_pulses: got %0d expected 3", pulse_cyc_q.size()); end
      n_checks++; if (bad_dir !== 0) begin n_fail++; $display("FAIL cw_dir: got %0d ccw pulses expected 0", bad_dir); end
      n_checks++; if (gap0 !== 6) begin n_fail++; $display("FAIL cw_gap0: got %0d expected 6", gap0); end
      n_checks++; if (gap1 !== 6) begin n_fail++; $display("FAIL cw_gap1: got %0d expected 6", gap1); end
      n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL cw_at_target: got %b expected 1", at_target); end
   endtask

   task automatic test_wrap();
      phys = 3'd0; sync = 1'b1;
      tick();
      sync = 1'b0;
      clear_log();
      ccw = 1'b1;
      tick();
      ccw = 1'b0;
      n_checks++; if (desired !== 3'd7) begin n_fail++; $display("FAIL wrap_desired: got %0d expected 7", desired); end
      repeat (20) tick();
      n_checks++; if (pulse_cyc_q.size() !== 1) begin n_fail++; $display("FAIL wrap_pulses: got %0d expected 1", pulse_cyc_q.size()); end
      n_checks++; if ((pulse_dir_q.size() > 0 ? pulse_dir_q[0] : 1'bx) !== 1'b0) begin n_fail++; $display("FAIL wrap_dir: expected ccw (0)"); end
      n_checks++; if (phys !== 3'd7) begin n_fail++; $display("FAIL wrap_final_pos: got %0d expected 7", phys); end
   endtask

   task automatic test_tie();
      clear_log();
      cw = 1'b1; ccw = 1'b1;
      repeat (5) tick();
      n_checks++; if (desired !== 3'd7) begin n_fail++; $display("FAIL tie_desired: got %0d expected 7", desired); end
      n_checks++; if (pulse_cyc_q.size() !== 0) begin n_fail++; $display("FAIL tie_pulses: got %0d expected 0", pulse_cyc_q.size()); end
      // half-circle distance: desired 4, physical 0 -> cw
      phys = 3'd4; sync = 1'b1;
      tick();
      sync = 1'b0; echo_en = 1'b0; phys = 3'd0;
      clear_log();
      repeat (8) tick();
      cw = 1'b0; ccw = 1'b0;
      n_checks++; if (desired !== 3'd4) begin n_fail++; $display("FAIL half_desired: got %0d expected 4", desired); end
      n_checks++; if ((pulse_dir_q.size() > 0 ? pulse_dir_q[0] : 1'bx) !== 1'b1) begin n_fail++; $display("FAIL half_dir: expected cw (1), pulses seen %0d", pulse_dir_q.size()); end
      phys = 3'd0; sync = 1'b1;
      tick();
      sync = 1'b0; echo_en = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_mid_move_sync();
      clear_log();
      cw = 1'b1;
      repeat (4) tick();
      cw = 1'b0;
      tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midsync_busy: got %b expected 0", busy); end
      n_checks++; if (desired !== 3'd1) begin n_fail++; $display("FAIL midsync_desired: got %0d expected 1", desired); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midsync_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      repeat (30) tick();
      n_checks++; if (pulse_cyc_q.size() !== 1) begin n_fail++; $display("FAIL midsync_pulses: got %0d expected 1", pulse_cyc_q.size()); end
   endtask

   task automatic test_back_to_back();
      int bad_dir;
      int gap0;
      clear_log();
      ccw = 1'b1;
      repeat (2) tick();
      ccw = 1'b0;
      n_checks++; if (desired !== 3'd7) begin n_fail++; $display("FAIL b2b_desired: got %0d expected 7", desired); end
      repeat (25) tick();
      bad_dir = 0;
      foreach (pulse_dir_q[i]) if (pulse_dir_q[i] !== 1'b0) bad_dir++;
      gap0 = (pulse_cyc_q.size() >= 2) ? pulse_cyc_q[1] - pulse_cyc_q[0] : -1;
      n_checks++; if (pulse_cyc_q.size() !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulse_cyc_q.size()); end
      n_checks++; if (bad_dir !== 0) begin n_fail++; $display("FAIL b2b_dir: got %0d cw pulses expected 0", bad_dir); end
      n_checks++; if (gap0 !== 6) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 6", gap0); end
      n_checks++; if (phys !== 3'd7) begin n_fail++; $display("FAIL b2b_final_pos: got %0d expected 7", phys); end
   endtask

   task automatic test_timeout();
      int p;
      int n_before;
      phys = 3'd0; sync = 1'b1;
      tick();
      sync = 1'b0; echo_en = 1'b0;
      clear_log();
      cw = 1'b1;
      tick();
      cw = 1'b0;
      tick();
`ifdef POSITION_STEPPER_TIMEOUT_EN
      p = (pulse_cyc_q.size() > 0) ? pulse_cyc_q[0] : cyc;
      while (cyc < p + 63) tick();
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0 at pulse+63", fault); end
      tick();
      n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b expected 1 at pulse+64", fault); end
      n_before = pulse_cyc_q.size();
      repeat (20) tick();
      n_checks++; if (pulse_cyc_q.size() !== n_before) begin n_fail++; $display("FAIL timeout_stopped: got %0d pulses expected %0d", pulse_cyc_q.size(), n_before); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", fault); end
`else
      p = 0;
      repeat (100) tick();
      n_before = pulse_cyc_q.size();
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL nofault_tied: got %b expected 0", fault); end
      n_checks++; if (n_before < 10) begin n_fail++; $display("FAIL nofault_keeps_stepping: got %0d pulses expected >= 10", n_before); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
`endif
      echo_en = 1'b1;
      repeat (2) tick();
      n_checks++; if (busy !== 1'b0 || p < 0) begin n_fail++; $display("FAIL timeout_settle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_async_reset();
      phys = 3'd0; sync = 1'b1;
      tick();
      sync = 1'b0;
      cw = 1'b1;
      tick();
      cw = 1'b0;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b1 || step_dir !== 1'b1) begin n_fail++; $display("FAIL arst_pre: busy %b dir %b expected 1 1", busy, step_dir); end
      #3;
      rst = 1'b1;
      #1;
      n_checks++; if (desired !== 3'd0) begin n_fail++; $display("FAIL arst_desired: got %0d expected 0", desired); end
      n_checks++; if (step_dir !== 1'b0) begin n_fail++; $display("FAIL arst_dir: got %b expected 0", step_dir); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
      n_checks++; if (step_pulse !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL arst_pulse_fault: pulse %b fault %b expected 0 0", step_pulse, fault); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL arst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_post_reset_seek();
      test_cw_move();
      test_wrap();
      test_tie();
      test_mid_move_sync();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
